// File: rtl/psram_cmd_sequencer.sv
// psram_cmd_sequencer: turns the UART command byte stream into PSRAM accesses.
//   Write: 0x00, addr_hi, addr_lo, data      Read: 0x01, addr_hi, addr_lo
// A read returns its data byte on the UART transmit side. An inter-byte
// timeout aborts stalled commands, and a saturating counter records every
// protocol error: bad opcode, timeout, or a byte arriving while busy.
`timescale 1ns/1ps
module psram_cmd_sequencer #(
   parameter int ADDR_W     = 16,
   parameter int TIMEOUT_US = 1000,
   parameter int CNT_W      = 10
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              tick_1us,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic [7:0]        err_cnt
);

   typedef enum logic [2:0] {
      IDLE, ADDR_HI, ADDR_LO, DATA, MEM_REQ, TX
   } state_t;

   state_t           state;
   logic [7:0]       addr_hi;
   logic [CNT_W-1:0] tmo_cnt;
   logic [15:0]      full_addr;
   logic             counting;
   logic             timeout_hit;
   logic             bad_op;
   logic             overrun;
   logic             err_event;

   // Both address bytes side by side; only the low ADDR_W bits reach the PSRAM.
   assign full_addr = {addr_hi, rx_data};

   // Error and timeout conditions. A byte arriving in the timeout cycle wins.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      counting    = 1'b0;
      timeout_hit = 1'b0;
      bad_op      = 1'b0;
      overrun     = 1'b0;
      counting    = (state == ADDR_HI) || (state == ADDR_LO) || (state == DATA);
      timeout_hit = counting && tick_1us && !rx_valid &&
                    (tmo_cnt == CNT_W'(TIMEOUT_US - 1));
      bad_op      = (state == IDLE) && rx_valid && (rx_data > 8'h01);
      overrun     = rx_valid && ((state == MEM_REQ) || (state == TX));
      err_event   = bad_op || timeout_hit || overrun;
   end

   // Inter-byte timeout counter. It runs only while a command is being received.
   // Every entry into a counting state happens on an accepted byte, which clears it.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         tmo_cnt <= '0;
      end else if (!counting || rx_valid || timeout_hit) begin
         tmo_cnt <= '0;
      end else if (tick_1us) begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end

   // Saturating error counter. Simultaneous error sources count once.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         err_cnt <= 8'h00;
      end else if (err_event && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

   // Command FSM with registered outputs. busy tracks the state being entered.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state     <= IDLE;
         addr_hi   <= 8'h00;
         tx_valid  <= 1'b0;
         tx_data   <= 8'h00;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'h00;
         busy      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values, independent of statement order.
         case (state)
            IDLE: begin
               if (rx_valid && (rx_data == 8'h00)) begin
                  mem_we <= 1'b1;
                  state  <= ADDR_HI;
                  busy   <= 1'b1;
               end else if (rx_valid && (rx_data == 8'h01)) begin
                  mem_we <= 1'b0;
                  state  <= ADDR_HI;
                  busy   <= 1'b1;
               end
            end
            ADDR_HI: begin
               if (rx_valid) begin
                  addr_hi <= rx_data;
                  state   <= ADDR_LO;
               end else if (timeout_hit) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            ADDR_LO: begin
               if (rx_valid) begin
                  mem_addr <= full_addr[ADDR_W-1:0];
                  if (mem_we) begin
                     state <= DATA;
                  end else begin
                     mem_req <= 1'b1;
                     state   <= MEM_REQ;
                  end
               end else if (timeout_hit) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            DATA: begin
               if (rx_valid) begin
                  mem_wdata <= rx_data;
                  mem_req   <= 1'b1;
                  state     <= MEM_REQ;
               end else if (timeout_hit) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            MEM_REQ: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (mem_we) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     tx_data  <= mem_rdata;
                     tx_valid <= 1'b1;
                     state    <= TX;
                  end
               end
            end
            TX: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  state    <= IDLE;
                  busy     <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
